// File: rtl/traffic_light_timed.sv
// traffic_light_timed
// Highway / farm-road intersection controller with parameterised phase
// durations. Farm green is extended by the car sensor between a minimum and
// a maximum. An all-red clearance phase follows each yellow. A latched
// pedestrian request is served by a farm phase, and ped_walk is shown for
// that whole farm green.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         synchronous active-low reset
//   c             farm-road car sensor (level, clk domain)
//   ped_req       pedestrian request to cross the highway (pulse or level)
//   light_highway {red,yellow,green} one-hot
//   light_farm    {red,yellow,green} one-hot
//   ped_walk      walk indication for the highway crossing
//   phase         current state code, for debug
//
// state  | code | meaning
// -------+------+---------------------------------------------
// HWY_G  | 0    | highway green, held until demand after min green
// HWY_Y  | 1    | highway yellow
// RED1   | 2    | all red, clearing toward farm green
// FARM_G | 3    | farm green, sensor-extended between min and max
// FARM_Y | 4    | farm yellow
// RED2   | 5    | all red, clearing toward highway green
module traffic_light_timed #(
  parameter int CNT_W          = 8,
  parameter int HWY_MIN_GREEN  = 8,
  parameter int FARM_MIN_GREEN = 4,
  parameter int FARM_MAX_GREEN = 10,
  parameter int YELLOW_TIME    = 3,
  parameter int ALL_RED_TIME   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       c,
  input  logic       ped_req,
  output logic [2:0] light_highway,
  output logic [2:0] light_farm,
  output logic       ped_walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    HWY_G  = 3'd0,
    HWY_Y  = 3'd1,
    RED1   = 3'd2,
    FARM_G = 3'd3,
    FARM_Y = 3'd4,
    RED2   = 3'd5
  } state_t;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  // Terminal timer values: timer k is the (k+1)th cycle in a state.
  localparam logic [CNT_W-1:0] TIMER_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] HWY_MIN_LAST  = CNT_W'(HWY_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] FARM_MIN_LAST = CNT_W'(FARM_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] FARM_MAX_LAST = CNT_W'(FARM_MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST   = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] ALL_RED_LAST  = CNT_W'(ALL_RED_TIME - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             ped_pending_q, ped_pending_d;
  logic             ped_walk_q, ped_walk_d;
  logic [2:0]       light_highway_q, light_highway_d;
  logic [2:0]       light_farm_q, light_farm_d;
  logic             enter_farm_g;

  always_comb begin
    state_d = state_q;
    case (state_q)
      HWY_G:  if ((timer_q >= HWY_MIN_LAST) && (c || ped_pending_q)) state_d = HWY_Y;
      HWY_Y:  if (timer_q == YELLOW_LAST)  state_d = RED1;
      RED1:   if (timer_q == ALL_RED_LAST) state_d = FARM_G;
      // The max cut-off wins even with a car still waiting.
      FARM_G: if (((timer_q >= FARM_MIN_LAST) && !c) || (timer_q == FARM_MAX_LAST))
                state_d = FARM_Y;
      FARM_Y: if (timer_q == YELLOW_LAST)  state_d = RED2;
      RED2:   if (timer_q == ALL_RED_LAST) state_d = HWY_G;
      default: state_d = HWY_G;
    endcase

    // Saturation only matters in HWY_G, the one state with no upper bound.
    if (state_d != state_q)        timer_d = '0;
    else if (timer_q == TIMER_MAX) timer_d = timer_q;
    else                           timer_d = timer_q + CNT_W'(1);

    enter_farm_g = (state_d == FARM_G) && (state_q != FARM_G);

    // A request landing on the entry edge is served by this farm phase, so
    // clearing takes priority over setting.
    ped_pending_d = ped_pending_q;
    if (enter_farm_g)                       ped_pending_d = 1'b0;
    else if (ped_req && state_q != FARM_G)  ped_pending_d = 1'b1;

    ped_walk_d = ped_walk_q;
    if (enter_farm_g)            ped_walk_d = ped_pending_q | ped_req;
    else if (state_d != FARM_G)  ped_walk_d = 1'b0;

    // Lights are decoded from the next state so they change with the state.
    light_highway_d = LIGHT_RED;
    light_farm_d    = LIGHT_RED;
    case (state_d)
      HWY_G:  light_highway_d = LIGHT_GREEN;
      HWY_Y:  light_highway_d = LIGHT_YELLOW;
      FARM_G: light_farm_d    = LIGHT_GREEN;
      FARM_Y: light_farm_d    = LIGHT_YELLOW;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= HWY_G;
      timer_q         <= '0;
      ped_pending_q   <= 1'b0;
      ped_walk_q      <= 1'b0;
      light_highway_q <= LIGHT_GREEN;
      light_farm_q    <= LIGHT_RED;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      ped_pending_q   <= ped_pending_d;
      ped_walk_q      <= ped_walk_d;
      light_highway_q <= light_highway_d;
      light_farm_q    <= light_farm_d;
    end
  end

  assign light_highway = light_highway_q;
  assign light_farm    = light_farm_q;
  assign ped_walk      = ped_walk_q;
  assign phase         = state_q;

endmodule

// File: tb/tb_traffic_light_timed.sv
// Directed bench for traffic_light_timed: a default-parameter instance and a
// short-timing instance (HWY_MIN_GREEN=2, YELLOW_TIME=1, ALL_RED_TIME=1).
module tb_traffic_light_timed;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       c = 1'b0, ped_req = 1'b0;
  logic       c2 = 1'b0, ped_req2 = 1'b0;
  logic [2:0] lh, lf, ph, lh2, lf2, ph2;
  logic       pw, pw2;
  int         tests = 0;
  int         fails = 0;

  localparam logic [2:0] P_HG = 3'd0, P_HY = 3'd1, P_R1 = 3'd2,
                         P_FG = 3'd3, P_FY = 3'd4, P_R2 = 3'd5;

  always #5 clk = ~clk;

  traffic_light_timed dut (
    .clk(clk), .rst_n(rst_n), .c(c), .ped_req(ped_req),
    .light_highway(lh), .light_farm(lf), .ped_walk(pw), .phase(ph)
  );

  traffic_light_timed #(
    .HWY_MIN_GREEN(2), .YELLOW_TIME(1), .ALL_RED_TIME(1)
  ) dut_fast (
    .clk(clk), .rst_n(rst_n), .c(c2), .ped_req(ped_req2),
    .light_highway(lh2), .light_farm(lf2), .ped_walk(pw2), .phase(ph2)
  );

  function automatic logic [2:0] exp_h(input logic [2:0] p);
    case (p)
      3'd0:    return 3'b001;
      3'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_f(input logic [2:0] p);
    case (p)
      3'd3:    return 3'b001;
      3'd4:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // Compares {light_highway, light_farm, ped_walk, phase} against the phase table.
  task automatic check(input string tag, input bit sel, input logic [2:0] p, input logic walk);
    logic [9:0] obs, expv;
    obs  = sel ? {lh2, lf2, pw2, ph2} : {lh, lf, pw, ph};
    expv = {exp_h(p), exp_f(p), walk, p};
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed h/f/walk/phase=%b required %b", tag, obs, expv);
    end
  endtask

  task automatic run_phase(input string tag, input bit sel, input logic [2:0] p,
                           input int n, input logic walk);
    for (int i = 0; i < n; i++) begin
      check(tag, sel, p, walk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    do_reset();

    // Idle: no demand holds highway green.
    run_phase("idle", 0, P_HG, 50, 1'b0);

    // Car held: max cut-off on farm green, then highway min green again.
    c = 1'b1;
    do_reset();
    run_phase("c_hg",  0, P_HG, 8, 1'b0);
    run_phase("c_hy",  0, P_HY, 3, 1'b0);
    run_phase("c_r1",  0, P_R1, 2, 1'b0);
    run_phase("c_fg",  0, P_FG, 10, 1'b0);
    run_phase("c_fy",  0, P_FY, 3, 1'b0);
    run_phase("c_r2",  0, P_R2, 2, 1'b0);
    run_phase("c_hg2", 0, P_HG, 8, 1'b0);
    run_phase("c_hy2", 0, P_HY, 1, 1'b0);

    // Car leaves at farm-green timer 5: 6 farm-green cycles.
    do_reset();
    run_phase("d5_hg", 0, P_HG, 8, 1'b0);
    run_phase("d5_hy", 0, P_HY, 3, 1'b0);
    run_phase("d5_r1", 0, P_R1, 2, 1'b0);
    run_phase("d5_fg", 0, P_FG, 5, 1'b0);
    c = 1'b0;
    run_phase("d5_fg", 0, P_FG, 1, 1'b0);
    run_phase("d5_fy", 0, P_FY, 3, 1'b0);
    run_phase("d5_r2", 0, P_R2, 2, 1'b0);
    run_phase("d5_hg2", 0, P_HG, 20, 1'b0);

    // Car leaves at farm-green timer 1: minimum of 4 cycles.
    c = 1'b1;
    do_reset();
    run_phase("d1_hg", 0, P_HG, 8, 1'b0);
    run_phase("d1_hy", 0, P_HY, 3, 1'b0);
    run_phase("d1_r1", 0, P_R1, 2, 1'b0);
    run_phase("d1_fg", 0, P_FG, 1, 1'b0);
    c = 1'b0;
    run_phase("d1_fg", 0, P_FG, 3, 1'b0);
    run_phase("d1_fy", 0, P_FY, 1, 1'b0);

    // Pedestrian pulse at highway-green timer 2, no car.
    do_reset();
    run_phase("ped_hg", 0, P_HG, 2, 1'b0);
    ped_req = 1'b1;
    run_phase("ped_hg", 0, P_HG, 1, 1'b0);
    ped_req = 1'b0;
    run_phase("ped_hg", 0, P_HG, 5, 1'b0);
    run_phase("ped_hy", 0, P_HY, 3, 1'b0);
    run_phase("ped_r1", 0, P_R1, 2, 1'b0);
    run_phase("ped_fg", 0, P_FG, 4, 1'b1);
    run_phase("ped_fy", 0, P_FY, 3, 1'b0);
    run_phase("ped_r2", 0, P_R2, 2, 1'b0);
    run_phase("ped_hold", 0, P_HG, 30, 1'b0);

    // Reset during a walking farm green.
    do_reset();
    run_phase("rw_hg", 0, P_HG, 1, 1'b0);
    ped_req = 1'b1;
    run_phase("rw_hg", 0, P_HG, 1, 1'b0);
    ped_req = 1'b0;
    run_phase("rw_hg", 0, P_HG, 6, 1'b0);
    run_phase("rw_hy", 0, P_HY, 3, 1'b0);
    run_phase("rw_r1", 0, P_R1, 2, 1'b0);
    run_phase("rw_fg", 0, P_FG, 2, 1'b1);
    do_reset();
    check("rst_mid_farm", 0, P_HG, 1'b0);
    run_phase("rw_hold", 0, P_HG, 30, 1'b0);

    // A pending request is dropped by reset.
    do_reset();
    run_phase("pd_hg", 0, P_HG, 1, 1'b0);
    ped_req = 1'b1;
    run_phase("pd_hg", 0, P_HG, 1, 1'b0);
    ped_req = 1'b0;
    run_phase("pd_hg", 0, P_HG, 1, 1'b0);
    do_reset();
    run_phase("pd_hold", 0, P_HG, 30, 1'b0);

    // Short timings on the second instance, car held.
    c2 = 1'b1;
    do_reset();
    run_phase("f_hg",  1, P_HG, 2, 1'b0);
    run_phase("f_hy",  1, P_HY, 1, 1'b0);
    run_phase("f_r1",  1, P_R1, 1, 1'b0);
    run_phase("f_fg",  1, P_FG, 10, 1'b0);
    run_phase("f_fy",  1, P_FY, 1, 1'b0);
    run_phase("f_r2",  1, P_R2, 1, 1'b0);
    run_phase("f_hg2", 1, P_HG, 2, 1'b0);
    run_phase("f_hy2", 1, P_HY, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/traffic_light_timed.md
Name: traffic_light_timed

Overview:
- Parametrised successor to the highway/farm-road controller.
- Per-phase durations are set by parameters and timed with an internal counter, not fixed state hops.
- Farm green is sensor-extended between a minimum and a maximum.
- Adds an all-red clearance phase, a latched pedestrian request with walk output, and a phase debug output.
- Sits at intersection level; inputs come from already-synchronised sensor logic in the clk domain.

Parameters:
- CNT_W, 8, phase timer width; every duration must be ≤ 2^CNT_W-1.
- HWY_MIN_GREEN, 8, minimum highway-green cycles.
- FARM_MIN_GREEN, 4, minimum farm-green cycles.
- FARM_MAX_GREEN, 10, maximum farm-green cycles; must be ≥ FARM_MIN_GREEN.
- YELLOW_TIME, 3, yellow cycles, both roads.
- ALL_RED_TIME, 2, all-red clearance cycles after each yellow.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- c  input  1  farm-road car sensor, level, synchronous to clk.
- ped_req  input  1  pedestrian request to cross highway; single-cycle pulse or level.
- light_highway  output  3  {red,yellow,green} one-hot: 100 red, 010 yellow, 001 green.
- light_farm  output  3  same encoding as light_highway.
- ped_walk  output  1  walk indication for the highway crossing.
- phase  output  3  current state encoding, for debug.

Behaviour:
- One clock, clk. Reset is synchronous and active-low: rst_n sampled 0 on a rising edge of clk.
- Reset values: state HWY_G, timer 0, ped_pending 0, light_highway 001, light_farm 100, ped_walk 0, phase 0.
- Reset mid-operation overrides everything on that edge and the same values apply.
- States and phase codes:
  - HWY_G = 0
  - HWY_Y = 1
  - RED1 = 2 (all red, going to farm)
  - FARM_G = 3
  - FARM_Y = 4
  - RED2 = 5 (all red, going to highway)
  - Codes 6 and 7 are unreachable; if ever reached, next edge goes to HWY_G with timer 0.
- Outputs are Moore: decoded from the state register only, and change on the same edge as the state.
- Output decode by state:
  - HWY_G: light_highway 001, light_farm 100.
  - HWY_Y: light_highway 010, light_farm 100.
  - RED1 and RED2: both 100.
  - FARM_G: light_highway 100, light_farm 001.
  - FARM_Y: light_highway 100, light_farm 010.
- Timer:
  - Cleared to 0 on every state transition, otherwise incremented each cycle.
  - Saturates at 2^CNT_W-1; only reachable in HWY_G.
  - Timer value k means the (k+1)th cycle in the current state.
- Transitions, evaluated each edge:
  - HWY_G -> HWY_Y when timer ≥ HWY_MIN_GREEN-1 and (c=1 or ped_pending=1). Otherwise stay; highway green is held indefinitely with no demand.
  - HWY_Y -> RED1 when timer = YELLOW_TIME-1.
  - RED1 -> FARM_G when timer = ALL_RED_TIME-1.
  - FARM_G -> FARM_Y when (timer ≥ FARM_MIN_GREEN-1 and c=0) or timer = FARM_MAX_GREEN-1. Max wins even if c=1.
  - FARM_Y -> RED2 when timer = YELLOW_TIME-1.
  - RED2 -> HWY_G when timer = ALL_RED_TIME-1.
  - Consequence: highway always gets at least HWY_MIN_GREEN cycles between farm greens, even with c held high.
- Pedestrian:
  - ped_pending is set on any edge with ped_req=1 while state ≠ FARM_G.
  - ped_pending is cleared on the edge entering FARM_G.
  - ped_walk is a registered flag set on entry to FARM_G if ped_pending was 1, and cleared on exit from FARM_G.
  - ped_req=1 during FARM_G is ignored; the current crossing is already served.
  - A pedestrian-only call (c=0) gives farm green exactly FARM_MIN_GREEN cycles, because c=0 ends it at the minimum.
- Simultaneous events:
  - ped_req on the RED1->FARM_G edge: pending is cleared and walk is set; the request is served.
  - c and ped_req together: a single farm phase serves both.

Test Plan:
- Reset, then release with defaults and c=0, ped_req=0, for 50 cycles -> light_highway=001, light_farm=100, phase=0 throughout; ped_walk=0.
- Release, then c=1 held -> sequence as below, then back to 001/100 with phase 0 for ≥ 8 cycles before the next yellow:
  - highway green 8 cycles
  - highway yellow (010) 3 cycles
  - all red (100/100) 2 cycles
  - farm green (001) exactly 10 cycles (max cut-off)
  - farm yellow 3 cycles
  - all red 2 cycles
- Farm phase entered with c=1, c dropped at farm-green timer=5 -> farm yellow begins on the next edge, giving 6 farm-green cycles. Separately, c dropped at timer=1 -> farm green lasts exactly 4 cycles.
- One-cycle ped_req pulse at highway-green timer=2, c=0 -> yellow after 8 highway-green cycles, and:
  - ped_walk=1 for exactly the 4 farm-green cycles;
  - ped_pending clear afterwards;
  - no second farm phase.
- Reset asserted for one edge during FARM_G with ped_walk=1 -> the next cycle shows light_highway=001, light_farm=100, ped_walk=0, phase=0, and a previously pending request is dropped.
- Override YELLOW_TIME=1, ALL_RED_TIME=1, HWY_MIN_GREEN=2 with c=1 -> yellow and all-red last 1 cycle each and highway green 2 cycles; no skipped or repeated phase codes.
